// File: rtl/ahb_default_slave_cfg_pkg.sv
// Shared types and constants for the configurable AHB default slave.
package ahb_default_slave_pkg;

  // Response sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } state_e;

  localparam logic [1:0] RSP_OKAY  = 2'b00;
  localparam logic [1:0] RSP_ERROR = 2'b01;

  // Wait-state counter geometry.
  localparam int WAIT_CNT_W = 4;
  localparam int WAIT_MAX   = 15;

  // HREADYOUT is low only while the slave is stretching the data phase.
  function automatic logic ready_of(state_e s);
    return !(s == WAIT || s == ERR1);
  endfunction

  // HRESP is ERROR for both cycles of the two-cycle error response.
  function automatic logic [1:0] resp_of(state_e s);
    return (s == ERR1 || s == ERR2) ? RSP_ERROR : RSP_OKAY;
  endfunction

endpackage

// File: rtl/ahb_default_slave_cfg_if.sv
// AHB slave-side bus bundle for the default slave.
//
// Handshake: a transfer is offered in the address phase when HSEL is high and
// HTRANS[1] is set (NONSEQ/SEQ); it is taken on the rising edge where HREADY is
// also high. The slave then owns the data phase, holding HREADYOUT low for each
// stretched cycle; the data phase completes on the first cycle with HREADYOUT
// high, and that same cycle may carry the next address phase.
interface ahb_default_slave_cfg_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [1:0]            HTRANS;
  logic                  HREADY;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HWRITE;
  logic                  HREADYOUT;
  logic [1:0]            HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;

  modport master (
    output HSEL, HTRANS, HREADY, HADDR, HWRITE,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HTRANS, HREADY, HADDR, HWRITE,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_default_slave_cfg_err_log.sv
// Offending-access log: last address/direction, saturating count, sticky irq.
module ahb_default_slave_err_log
  import ahb_default_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  log_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  write_i,
  input  logic                  clr_i,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic                  err_write_o,
  output logic [CNT_WIDTH-1:0]  err_count_o,
  output logic                  err_irq_o
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [CNT_WIDTH-1:0]  count_base;
  logic                  irq_q, irq_d;

  // Next log state: clear applies first so a coincident access still counts as one.
  always_comb begin
    addr_d     = addr_q;
    write_d    = write_q;
    count_base = clr_i ? '0 : count_q;
    count_d    = count_base;
    irq_d      = irq_q & ~clr_i;
    if (log_en_i) begin
      addr_d  = addr_i;
      write_d = write_i;
      irq_d   = 1'b1;
      if (!(&count_base)) begin
        count_d = count_base + CNT_WIDTH'(1);
      end
    end
  end

  // Log registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      count_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      write_q <= write_d;
      count_q <= count_d;
      irq_q   <= irq_d;
    end
  end

  assign err_addr_o  = addr_q;
  assign err_write_o = write_q;
  assign err_count_o = count_q;
  assign err_irq_o   = irq_q;

endmodule

// File: rtl/ahb_default_slave_cfg.sv
// Configurable AHB default slave: wait states, ERROR or OKAY/constant response,
// and logging of every access that lands in unmapped space.
module ahb_default_slave_cfg
  import ahb_default_slave_pkg::*;
#(
  parameter int                    WAIT_STATES = 0,
  parameter bit                    ERR_MODE    = 1'b1,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    CNT_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] RDATA_VALUE = '0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb_default_slave_cfg_if.slave bus,
  input  logic                  err_clr,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_write,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_irq,
  output state_e                dbg_state
);

  // The wait counter is only four bits; larger settings cannot be honoured.
  if (WAIT_STATES < 0 || WAIT_STATES > WAIT_MAX) begin : g_bad_wait_states
    $error("ahb_default_slave_cfg: WAIT_STATES must be in 0..15");
  end

  localparam bit                    HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [WAIT_CNT_W-1:0] WS_LOAD  =
    WAIT_CNT_W'(HAS_WAIT ? WAIT_STATES - 1 : 0);

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    accept;
  logic                    unused_htrans0;

  // HTRANS[0] only separates NONSEQ from SEQ (or IDLE from BUSY); both are
  // treated alike here.
  assign unused_htrans0 = bus.HTRANS[0];

  // New transfers are only looked at when the slave drives HREADYOUT high,
  // i.e. in IDLE or in the final ERROR cycle.
  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] &
                  (state_q == IDLE || state_q == ERR2);

  // Next-state and wait-counter logic for the response sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, ERR2: begin
        state_d = IDLE;
        if (accept) begin
          if (HAS_WAIT) begin
            state_d = WAIT;
            cnt_d   = WS_LOAD;
          end else if (ERR_MODE) begin
            state_d = ERR1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ERR_MODE ? ERR1 : IDLE;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      ERR1: begin
        state_d = ERR2;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and wait-counter registers; reset abandons any response in flight.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.HREADYOUT = ready_of(state_q);
  assign bus.HRESP     = resp_of(state_q);
  assign bus.HRDATA    = RDATA_VALUE;
  assign dbg_state     = state_q;

  ahb_default_slave_err_log #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_err_log (
    .clk_i       (HCLK),
    .rst_i       (HRESET),
    .log_en_i    (accept),
    .addr_i      (bus.HADDR),
    .write_i     (bus.HWRITE),
    .clr_i       (err_clr),
    .err_addr_o  (err_addr),
    .err_write_o (err_write),
    .err_count_o (err_count),
    .err_irq_o   (err_irq)
  );

endmodule

// File: tb/tb_ahb_default_slave_cfg.sv
// Bench for ahb_default_slave_cfg: three configurations driven with directed
// transfers; a monitor closes each data phase against an expected queue.
module tb_ahb_default_slave_cfg;
  import ahb_default_slave_pkg::*;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  typedef struct packed {
    logic [1:0]  dut;
    logic [3:0]  n_low;
    logic [1:0]  resp;
    logic        chk_rdata;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  cnt;
    logic        irq;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus arrays ----------------
  logic        hsel   [3];
  logic [1:0]  htrans [3];
  logic [31:0] haddr  [3];
  logic        hwrite [3];
  logic        clr    [3];

  // ---------------- observed arrays ----------------
  logic        rdy   [3];
  logic [1:0]  rsp   [3];
  logic [31:0] rdata [3];
  logic [31:0] eaddr [3];
  logic        ewr   [3];
  logic [7:0]  ecnt  [3];
  logic        eirq  [3];
  state_e      st    [3];

  logic [31:0] eaddr0, eaddr1, eaddr2;
  logic        ewr0, ewr1, ewr2;
  logic [1:0]  ecnt0;
  logic [7:0]  ecnt1, ecnt2;
  logic        eirq0, eirq1, eirq2;
  state_e      st0, st1, st2;

  ahb_default_slave_cfg_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  ahb_default_slave_cfg_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
  ahb_default_slave_cfg_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

  // Single-slave bus: HREADY follows this slave's HREADYOUT.
  assign bus0.HSEL = hsel[0]; assign bus0.HTRANS = htrans[0];
  assign bus0.HADDR = haddr[0]; assign bus0.HWRITE = hwrite[0];
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus1.HSEL = hsel[1]; assign bus1.HTRANS = htrans[1];
  assign bus1.HADDR = haddr[1]; assign bus1.HWRITE = hwrite[1];
  assign bus1.HREADY = bus1.HREADYOUT;
  assign bus2.HSEL = hsel[2]; assign bus2.HTRANS = htrans[2];
  assign bus2.HADDR = haddr[2]; assign bus2.HWRITE = hwrite[2];
  assign bus2.HREADY = bus2.HREADYOUT;

  assign rdy[0] = bus0.HREADYOUT; assign rsp[0] = bus0.HRESP; assign rdata[0] = bus0.HRDATA;
  assign rdy[1] = bus1.HREADYOUT; assign rsp[1] = bus1.HRESP; assign rdata[1] = bus1.HRDATA;
  assign rdy[2] = bus2.HREADYOUT; assign rsp[2] = bus2.HRESP; assign rdata[2] = bus2.HRDATA;
  assign eaddr[0] = eaddr0; assign ewr[0] = ewr0; assign ecnt[0] = {6'b0, ecnt0};
  assign eirq[0] = eirq0; assign st[0] = st0;
  assign eaddr[1] = eaddr1; assign ewr[1] = ewr1; assign ecnt[1] = ecnt1;
  assign eirq[1] = eirq1; assign st[1] = st1;
  assign eaddr[2] = eaddr2; assign ewr[2] = ewr2; assign ecnt[2] = ecnt2;
  assign eirq[2] = eirq2; assign st[2] = st2;

  // DUT 0: zero waits, ERROR mode, 2-bit counter (saturation checks).
  ahb_default_slave_cfg #(
    .WAIT_STATES(0), .ERR_MODE(1'b1), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .CNT_WIDTH(2), .RDATA_VALUE(32'h0)
  ) dut0 (
    .HCLK(clk), .HRESET(rst), .bus(bus0), .err_clr(clr[0]),
    .err_addr(eaddr0), .err_write(ewr0), .err_count(ecnt0), .err_irq(eirq0),
    .dbg_state(st0)
  );

  // DUT 1: three waits, ERROR mode.
  ahb_default_slave_cfg #(
    .WAIT_STATES(3), .ERR_MODE(1'b1), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .CNT_WIDTH(8), .RDATA_VALUE(32'h0)
  ) dut1 (
    .HCLK(clk), .HRESET(rst), .bus(bus1), .err_clr(clr[1]),
    .err_addr(eaddr1), .err_write(ewr1), .err_count(ecnt1), .err_irq(eirq1),
    .dbg_state(st1)
  );

  // DUT 2: two waits, OKAY mode, read-as-constant.
  ahb_default_slave_cfg #(
    .WAIT_STATES(2), .ERR_MODE(1'b0), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .CNT_WIDTH(8), .RDATA_VALUE(32'hDEAD_BEEF)
  ) dut2 (
    .HCLK(clk), .HRESET(rst), .bus(bus2), .err_clr(clr[2]),
    .err_addr(eaddr2), .err_write(ewr2), .err_count(ecnt2), .err_irq(eirq2),
    .dbg_state(st2)
  );

  // ---------------- scoreboard ----------------
  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_quiet(input int d, input string tag);
    check({tag, "_hreadyout"}, 64'(rdy[d]), 64'd1);
    check({tag, "_hresp"}, 64'(rsp[d]), 64'(RSP_OKAY));
    check({tag, "_err_addr"}, 64'(eaddr[d]), 64'd0);
    check({tag, "_err_write"}, 64'(ewr[d]), 64'd0);
    check({tag, "_err_count"}, 64'(ecnt[d]), 64'd0);
    check({tag, "_err_irq"}, 64'(eirq[d]), 64'd0);
    check({tag, "_state"}, 64'(st[d]), 64'(IDLE));
  endtask

  // ---------------- driver ----------------
  // Issues one transfer (held until accepted), optionally pushing its expectation.
  task automatic xfer(input int d, input logic [1:0] tr, input logic [31:0] a,
                      input logic w, input logic c, input logic push,
                      input logic [3:0] nl, input logic [1:0] rs,
                      input logic chk, input logic [31:0] rd,
                      input logic [7:0] cnt, input logic irq);
    exp_t e;
    logic ok;
    if (push) begin
      e.dut = 2'(d); e.n_low = nl; e.resp = rs; e.chk_rdata = chk;
      e.rdata = rd; e.addr = a; e.wr = w; e.cnt = cnt; e.irq = irq;
      exp_q.push_back(e);
    end
    hsel[d] = 1'b1; htrans[d] = tr; haddr[d] = a; hwrite[d] = w; clr[d] = c;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rdy[d]) begin
        ok = 1'b1;
        break;
      end
    end
    check("xfer_accepted", 64'(ok), 64'd1);
    @(posedge clk); #1;
    hsel[d] = 1'b0; htrans[d] = T_IDLE; clr[d] = 1'b0;
  endtask

  // ---------------- monitor ----------------
  int         n_low    [3];
  int         n_err    [3];
  logic       busy     [3];
  logic [1:0] last_rsp [3];

  initial begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      busy[d] = 1'b0; n_low[d] = 0; n_err[d] = 0; last_rsp[d] = RSP_OKAY;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rst) begin
          busy[d] = 1'b0;
          continue;
        end
        if (busy[d]) begin
          if (!rdy[d]) begin
            n_low[d]++;
            if (rsp[d] == RSP_ERROR) n_err[d]++;
            last_rsp[d] = rsp[d];
          end else begin
            busy[d] = 1'b0;
            if (exp_q.size() == 0) begin
              tests_run++;
              tests_failed++;
              $display("FAIL unexpected_completion: dut=%0d has no expected entry", d);
            end else begin
              e = exp_q.pop_front();
              check("resp_dut", 64'(d), 64'(e.dut));
              check("wait_cycles", 64'(n_low[d]), 64'(e.n_low));
              check("error_low_cycles", 64'(n_err[d]), (e.resp == RSP_ERROR) ? 64'd1 : 64'd0);
              check("final_hresp", 64'(rsp[d]), 64'(e.resp));
              if (e.n_low != 0) check("last_low_hresp", 64'(last_rsp[d]), 64'(e.resp));
              if (e.chk_rdata) check("hrdata", 64'(rdata[d]), 64'(e.rdata));
              check("err_addr", 64'(eaddr[d]), 64'(e.addr));
              check("err_write", 64'(ewr[d]), 64'(e.wr));
              check("err_count", 64'(ecnt[d]), 64'(e.cnt));
              check("err_irq", 64'(eirq[d]), 64'(e.irq));
            end
          end
        end
        if (hsel[d] && rdy[d] && htrans[d][1]) begin
          busy[d] = 1'b1; n_low[d] = 0; n_err[d] = 0; last_rsp[d] = RSP_OKAY;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    for (int d = 0; d < 3; d++) begin
      hsel[d] = 1'b0; htrans[d] = T_IDLE; haddr[d] = '0; hwrite[d] = 1'b0; clr[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet(0, "reset0");
    check_quiet(1, "reset1");
    check_quiet(2, "reset2");
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero-wait ERROR response: data phase ERR1 (low) then ERR2 (high).
    xfer(0, T_NONSEQ, 32'h4000_0000, 1'b0, 1'b0, 1'b1, 4'd1, RSP_ERROR, 1'b0, 32'h0, 8'd1, 1'b1);
    // Back-to-back: second transfer taken in ERR2, ERR1 must follow at once.
    xfer(0, T_NONSEQ, 32'h4000_0004, 1'b1, 1'b0, 1'b1, 4'd1, RSP_ERROR, 1'b0, 32'h0, 8'd2, 1'b1);
    xfer(0, T_NONSEQ, 32'h4000_0008, 1'b0, 1'b0, 1'b1, 4'd1, RSP_ERROR, 1'b0, 32'h0, 8'd3, 1'b1);
    @(negedge clk);
    check("b2b_immediate_err1", 64'(st[0]), 64'(ERR1));
    // 2-bit counter holds at 3.
    xfer(0, T_SEQ,    32'h4000_000C, 1'b1, 1'b0, 1'b1, 4'd1, RSP_ERROR, 1'b0, 32'h0, 8'd3, 1'b1);
    xfer(0, T_NONSEQ, 32'h4000_0010, 1'b0, 1'b0, 1'b1, 4'd1, RSP_ERROR, 1'b0, 32'h0, 8'd3, 1'b1);
    repeat (4) @(posedge clk); #1;

    // Clear coinciding with an accepted transfer: set wins, count restarts at 1.
    xfer(0, T_NONSEQ, 32'h5000_0000, 1'b1, 1'b1, 1'b1, 4'd1, RSP_ERROR, 1'b0, 32'h0, 8'd1, 1'b1);
    repeat (4) @(posedge clk); #1;

    // Clear on its own.
    clr[0] = 1'b1;
    @(posedge clk); #1;
    clr[0] = 1'b0;
    @(negedge clk);
    check("clr_count", 64'(ecnt[0]), 64'd0);
    check("clr_irq", 64'(eirq[0]), 64'd0);
    check("clr_keeps_addr", 64'(eaddr[0]), 64'h5000_0000);

    // IDLE and BUSY with HSEL high: zero-wait OKAY, nothing logged.
    hsel[0] = 1'b1; htrans[0] = T_IDLE; haddr[0] = 32'h7000_0000; hwrite[0] = 1'b1;
    @(negedge clk);
    check("idle_hreadyout", 64'(rdy[0]), 64'd1);
    check("idle_hresp", 64'(rsp[0]), 64'(RSP_OKAY));
    @(posedge clk); #1;
    htrans[0] = T_BUSY;
    @(negedge clk);
    check("busy_hreadyout", 64'(rdy[0]), 64'd1);
    check("busy_hresp", 64'(rsp[0]), 64'(RSP_OKAY));
    check("after_idle_state", 64'(st[0]), 64'(IDLE));
    check("after_idle_count", 64'(ecnt[0]), 64'd0);
    @(posedge clk); #1;
    hsel[0] = 1'b0; htrans[0] = T_IDLE;
    @(negedge clk);
    check("after_busy_count", 64'(ecnt[0]), 64'd0);
    check("after_busy_irq", 64'(eirq[0]), 64'd0);
    check("after_busy_addr", 64'(eaddr[0]), 64'h5000_0000);
    @(posedge clk); #1;

    // Three waits then ERR1 (four low cycles), ERROR on the last two.
    xfer(1, T_NONSEQ, 32'h4000_1000, 1'b1, 1'b0, 1'b1, 4'd4, RSP_ERROR, 1'b0, 32'h0, 8'd1, 1'b1);
    xfer(1, T_SEQ,    32'h4000_2000, 1'b0, 1'b0, 1'b1, 4'd4, RSP_ERROR, 1'b0, 32'h0, 8'd2, 1'b1);
    repeat (8) @(posedge clk); #1;

    // OKAY mode: two waits, read-as-constant, writes ignored but logged.
    xfer(2, T_NONSEQ, 32'h4000_3000, 1'b0, 1'b0, 1'b1, 4'd2, RSP_OKAY, 1'b1, 32'hDEAD_BEEF, 8'd1, 1'b1);
    xfer(2, T_NONSEQ, 32'h4000_3004, 1'b1, 1'b0, 1'b1, 4'd2, RSP_OKAY, 1'b1, 32'hDEAD_BEEF, 8'd2, 1'b1);
    repeat (6) @(posedge clk); #1;

    // Reset in the middle of a wait sequence.
    hsel[1] = 1'b1; htrans[1] = T_NONSEQ; haddr[1] = 32'h6000_0000; hwrite[1] = 1'b1;
    @(posedge clk); #1;
    hsel[1] = 1'b0; htrans[1] = T_IDLE;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_reset_in_wait", 64'(st[1]), 64'(WAIT));
    check("pre_reset_hreadyout", 64'(rdy[1]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_quiet(1, "midreset1");
    check("midreset2_count", 64'(ecnt[2]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
